pll_trim_controller: RTL and testbench

Digital frequency-lock controller for a ring-oscillator PLL. It counts fast `clock` cycles per period of the slow reference `osc` and compares the count with the divider ratio `div`. It then walks a 7-bit trim accumulator up or down, and drives a 26-bit thermometer-coded `trim` word to the oscillator's delay-trim inputs. It sits between the reference-clock pad and the ring-oscillator trim bank in the clocking block.

---
 rtl/pll_trim_controller.sv | 106 ++++++++++
 tb/tb_pll_trim_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pll_trim_controller.sv
// pll_trim_controller
//
// Frequency-lock controller for a ring-oscillator PLL. It counts `clock` cycles in each half
// period of the slow reference `osc`. On every reference edge it compares the last full-period
// count with the target ratio `div`, then steps a 7-bit trim accumulator up (oscillator too fast)
// or down (too slow). The upper five accumulator bits drive a 26-bit thermometer trim word.
//
// Ports:
//   clock  in   1   fast clock being trimmed (sole clock domain, rising edge)
//   reset  in   1   asynchronous active-low reset, clears all state
//   osc    in   1   slow reference clock, asynchronous to `clock`
//   div    in   5   target `clock` cycles per `osc` period (quasi-static)
//   trim   out  26  thermometer trim code, more ones = more delay
//
// Build option:
//   PLL_CTRL_DEADBAND_EN  when defined, the controller holds while the period sum is within +/-1
//                         of `div`; otherwise an exact comparison is used.

module pll_trim_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        osc,
    input  logic [4:0]  div,
    output logic [25:0] trim
);

    logic [2:0] oscbuf_q, oscbuf_d;
    logic [2:0] prep_q,   prep_d;
    logic [4:0] count0_q, count0_d;
    logic [4:0] count1_q, count1_d;
    logic [6:0] tval_q,   tval_d;

    logic       edge_ev;
    logic [5:0] sum;
    logic [5:0] div_ext;
    logic       go_up;
    logic       go_dn;
    logic [4:0] tint;

    // Two flops of synchronisation ahead of the compare stage; either polarity is an edge.
    assign edge_ev = oscbuf_q[2] ^ oscbuf_q[1];

    // Both counters are at most 31, so a 6-bit sum cannot overflow.
    assign sum     = {1'b0, count0_q} + {1'b0, count1_q};
    assign div_ext = {1'b0, div};

`ifdef PLL_CTRL_DEADBAND_EN
    // sum <= 62, so sum + 1 still fits in 6 bits; div + 1 <= 32.
    assign go_up = sum > (div_ext + 6'd1);
    assign go_dn = (sum + 6'd1) < div_ext;
`else
    assign go_up = sum > div_ext;
    assign go_dn = sum < div_ext;
`endif

    always_comb begin
        oscbuf_d = {oscbuf_q[1:0], osc};
        prep_d   = prep_q;
        count0_d = count0_q;
        count1_d = count1_q;
        tval_d   = tval_q;

        if (edge_ev) begin
            count1_d = count0_q;
            count0_d = 5'd1;
            prep_d   = {prep_q[1:0], 1'b1};
            // Warm-up: the first three edges only fill the counters with valid half periods.
            if (prep_q == 3'b111) begin
                if (go_up && (tval_q != 7'd127)) begin
                    tval_d = tval_q + 7'd1;
                end else if (go_dn && (tval_q != 7'd0)) begin
                    tval_d = tval_q - 7'd1;
                end
            end
        end else if (count0_q != 5'd31) begin
            count0_d = count0_q + 5'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oscbuf_q <= 3'd0;
            prep_q   <= 3'd0;
            count0_q <= 5'd0;
            count1_q <= 5'd0;
            tval_q   <= 7'd0;
        end else begin
            oscbuf_q <= oscbuf_d;
            prep_q   <= prep_d;
            count0_q <= count0_d;
            count1_q <= count1_d;
            tval_q   <= tval_d;
        end
    end

    // Dropping the two LSBs means one trim bit per four accumulator steps, hiding dither.
    assign tint = tval_q[6:2];

    always_comb begin
        trim = 26'd0;
        for (int i = 0; i < 26; i++) begin
            trim[i] = (tint > 5'(i));
        end
    end

endmodule

// File: tb/tb_pll_trim_controller.sv
// Directed self-checking bench for pll_trim_controller.
// clock period 10 ns; osc is toggled every 4 clock cycles (80 ns period), so in steady state each
// qualified reference edge sees sum = 8. Expected values below are hand-derived from that.

module tb_pll_trim_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        osc   = 1'b0;
    logic [4:0]  div   = 5'd8;
    logic [25:0] trim;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pll_trim_controller dut (
        .clock (clock),
        .reset (reset),
        .osc   (osc),
        .div   (div),
        .trim  (trim)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Assert reset asynchronously, check the cleared state, release and idle with osc low.
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        osc   = 1'b0;
        #1;
        check_val({tag, "_trim"},   32'(trim),         32'h0);
        check_val({tag, "_tval"},   32'(dut.tval_q),   32'h0);
        check_val({tag, "_count0"}, 32'(dut.count0_q), 32'h0);
        check_val({tag, "_count1"}, 32'(dut.count1_q), 32'h0);
        check_val({tag, "_prep"},   32'(dut.prep_q),   32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    // Apply n osc half periods; returns 3 cycles after the last toggle so the update has landed.
    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            osc = ~osc;
            repeat (3) @(negedge clock);
        end
    endtask

    initial begin
        // Lock hold: div = 8 matches the reference exactly.
        do_reset("rst0");
        div = 5'd8;
        run_edges(30);
        check_val("lock_tval",   32'(dut.tval_q),   32'd0);
        check_val("lock_trim",   32'(trim),         32'h0);
        check_val("lock_count1", 32'(dut.count1_q), 32'd4);

        // Stalled reference: count0 saturates at 31.
        do_reset("rst1");
        repeat (40) @(negedge clock);
        check_val("count0_sat", 32'(dut.count0_q), 32'd31);

        // Too slow from the floor: no underflow.
        do_reset("rst2");
        div = 5'd16;
        run_edges(20);
        check_val("slow_tval", 32'(dut.tval_q), 32'd0);
        check_val("slow_trim", 32'(trim),       32'h0);

        // Too fast: +1 per qualified edge starting at the 4th edge.
        do_reset("rst3");
        div = 5'd4;
        run_edges(3);
        check_val("fast_warmup_tval", 32'(dut.tval_q), 32'd0);
        run_edges(1);
        check_val("fast_e4_tval", 32'(dut.tval_q), 32'd1);
        run_edges(2);
        check_val("fast_e6_tval", 32'(dut.tval_q), 32'd3);
        check_val("fast_e6_trim", 32'(trim),       32'h0);
        run_edges(1);
        check_val("fast_e7_tval", 32'(dut.tval_q), 32'd4);
        check_val("fast_e7_trim", 32'(trim),       32'h1);
        run_edges(4);
        check_val("fast_e11_tval", 32'(dut.tval_q), 32'd8);
        check_val("fast_e11_trim", 32'(trim),       32'h3);
        run_edges(95);
        check_val("fast_t103_tval", 32'(dut.tval_q), 32'd103);
        check_val("fast_t103_trim", 32'(trim),       32'h1FF_FFFF);
        run_edges(1);
        check_val("fast_t104_trim", 32'(trim),       32'h3FF_FFFF);
        run_edges(23);
        check_val("fast_sat_tval", 32'(dut.tval_q), 32'd127);
        run_edges(10);
        check_val("fast_hold_tval", 32'(dut.tval_q), 32'd127);
        check_val("fast_hold_trim", 32'(trim),       32'h3FF_FFFF);

        // Recovery: div change applies at the next qualified edge, -1 per edge.
        div = 5'd16;
        run_edges(1);
        check_val("rec_t126_tval", 32'(dut.tval_q), 32'd126);
        check_val("rec_t126_trim", 32'(trim),       32'h3FF_FFFF);
        run_edges(23);
        check_val("rec_t103_tval", 32'(dut.tval_q), 32'd103);
        check_val("rec_t103_trim", 32'(trim),       32'h1FF_FFFF);
        run_edges(103);
        check_val("rec_floor_tval", 32'(dut.tval_q), 32'd0);
        check_val("rec_floor_trim", 32'(trim),       32'h0);
        run_edges(5);
        check_val("rec_hold_tval", 32'(dut.tval_q), 32'd0);

        // Reset mid-run: clears immediately, then warm-up restarts.
        do_reset("rst4");
        div = 5'd4;
        run_edges(11);
        check_val("mid_pre_trim", 32'(trim), 32'h3);
        do_reset("mid");
        run_edges(3);
        check_val("mid_warmup_tval", 32'(dut.tval_q), 32'd0);
        run_edges(1);
        check_val("mid_e4_tval", 32'(dut.tval_q), 32'd1);

        // div = 0: every qualified edge increments.
        do_reset("rst5");
        div = 5'd0;
        run_edges(8);
        check_val("div0_tval", 32'(dut.tval_q), 32'd5);

        // Near-lock behaviour differs between exact and deadband builds.
        do_reset("rst6");
        div = 5'd7;
        run_edges(10);
`ifdef PLL_CTRL_DEADBAND_EN
        check_val("div7_tval", 32'(dut.tval_q), 32'd0);
        check_val("div7_trim", 32'(trim),       32'h0);
`else
        check_val("div7_tval", 32'(dut.tval_q), 32'd7);
        check_val("div7_trim", 32'(trim),       32'h1);
`endif
        do_reset("rst7");
        div = 5'd6;
        run_edges(10);
        check_val("div6_tval", 32'(dut.tval_q), 32'd7);
        check_val("div6_trim", 32'(trim),       32'h1);
        div = 5'd9;
        run_edges(4);
`ifdef PLL_CTRL_DEADBAND_EN
        check_val("div9_tval", 32'(dut.tval_q), 32'd7);
`else
        check_val("div9_tval", 32'(dut.tval_q), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
